// File: rtl/quad_decoder.sv
// Quadrature encoder receiver: 2-FF synchronisers, per-phase persistence filter,
// 4x decode into position/direction/step, and windowed saturating velocity.
module quad_decoder #(
    parameter int POS_W      = 16,
    parameter int VEL_W      = 12,
    parameter int FILT_LEN   = 4,
    parameter int WIN_CYCLES = 100000
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             pos_clr,
    input  logic             err_clr,
    output logic [POS_W-1:0] pos,
    output logic             dir,
    output logic             step,
    output logic [VEL_W-1:0] vel,
    output logic             vel_valid,
    output logic             err
);

    localparam int FCNT_W  = $clog2(FILT_LEN + 1);
    localparam int PRIME_N = FILT_LEN + 2;
    localparam int PRIME_W = $clog2(PRIME_N + 1);
    localparam int WIN_W   = $clog2(WIN_CYCLES);
    localparam int ACC_W   = VEL_W + 2;

    localparam logic [FCNT_W-1:0]  FCNT_LAST  = FCNT_W'(FILT_LEN - 1);
    localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(PRIME_N);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WIN_CYCLES - 1);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] VEL_MAX_EXT = {3'b000, {(VEL_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] VEL_MIN_EXT = {3'b111, {(VEL_W-1){1'b0}}};
    localparam logic [VEL_W-1:0] VEL_MAX = {1'b0, {(VEL_W-1){1'b1}}};
    localparam logic [VEL_W-1:0] VEL_MIN = {1'b1, {(VEL_W-1){1'b0}}};

    // Bit 1 is phase A, bit 0 is phase B throughout.
    logic [1:0] enc_in;
    logic [1:0] sync2;
    logic [1:0] filt;
    assign enc_in = {enc_a, enc_b};

    // ---------------- priming after reset release ----------------
    logic [PRIME_W-1:0] prime_q, prime_d;
    logic               priming;

    always_comb begin
        priming = (prime_q != PRIME_DONE);
        prime_d = priming ? prime_q + 1'b1 : prime_q;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) prime_q <= '0;
        else        prime_q <= prime_d;
    end

    // ---------------- per-phase synchroniser and filter ----------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_phase
            logic              s1_q, s2_q;
            logic              f_q, f_d;
            logic [FCNT_W-1:0] c_q, c_d;

            always_comb begin
                f_d = f_q;
                c_d = '0;
                if (priming) begin
                    f_d = s2_q;
                end else if (s2_q != f_q) begin
                    if (c_q == FCNT_LAST) f_d = s2_q;
                    else                  c_d = c_q + 1'b1;
                end
            end

            always_ff @(posedge clk_sys or negedge rst_n) begin
                if (!rst_n) begin
                    s1_q <= 1'b0;
                    s2_q <= 1'b0;
                    f_q  <= 1'b0;
                    c_q  <= '0;
                end else begin
                    s1_q <= enc_in[gi];
                    s2_q <= s1_q;
                    f_q  <= f_d;
                    c_q  <= c_d;
                end
            end

            assign sync2[gi] = s2_q;
            assign filt[gi]  = f_q;
        end
    endgenerate

    // ---------------- decode ----------------
    logic [1:0]       prev_q, prev_d;
    logic [3:0]       trans;
    logic             fwd, rev, illegal;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d, step_q, step_d, err_q, err_d;

    always_comb begin
        trans   = {prev_q, filt};
        fwd     = 1'b0;
        rev     = 1'b0;
        illegal = 1'b0;
        if (!priming) begin
            case (trans)
                4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd     = 1'b1;
                4'b0010, 4'b1011, 4'b1101, 4'b0100: rev     = 1'b1;
                4'b0011, 4'b1100, 4'b0110, 4'b1001: illegal = 1'b1;
                default: ;
            endcase
        end

        // During priming prev tracks the same value loaded into filt so the
        // first live comparison sees no change.
        prev_d = priming ? sync2 : filt;
        step_d = fwd | rev;
        dir_d  = fwd ? 1'b1 : (rev ? 1'b0 : dir_q);

        pos_d = pos_q;
        if (fwd)      pos_d = pos_q + 1'b1;
        else if (rev) pos_d = pos_q - 1'b1;
        if (pos_clr)  pos_d = '0;

        err_d = err_q;
        if (err_clr) err_d = 1'b0;
        if (illegal) err_d = 1'b1;
    end

    // ---------------- velocity window ----------------
    logic [WIN_W-1:0]        win_q, win_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, acc_step;
    logic [VEL_W-1:0]        vel_q, vel_d;
    logic                    vel_valid_q, vel_valid_d;
    logic                    win_end;

    always_comb begin
        win_end = (win_q == WIN_LAST);
        win_d   = win_end ? '0 : win_q + 1'b1;

        acc_step = acc_q;
        if (fwd && acc_q != ACC_MAX)      acc_step = acc_q + ACC_W'(1);
        else if (rev && acc_q != ACC_MIN) acc_step = acc_q - ACC_W'(1);

        acc_d = (win_end || pos_clr) ? '0 : acc_step;

        vel_d = vel_q;
        if (win_end) begin
            if (acc_step > VEL_MAX_EXT)      vel_d = VEL_MAX;
            else if (acc_step < VEL_MIN_EXT) vel_d = VEL_MIN;
            else                             vel_d = acc_step[VEL_W-1:0];
        end
        vel_valid_d = win_end;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            prev_q      <= 2'b00;
            pos_q       <= '0;
            dir_q       <= 1'b1;
            step_q      <= 1'b0;
            err_q       <= 1'b0;
            win_q       <= '0;
            acc_q       <= '0;
            vel_q       <= '0;
            vel_valid_q <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            step_q      <= step_d;
            err_q       <= err_d;
            win_q       <= win_d;
            acc_q       <= acc_d;
            vel_q       <= vel_d;
            vel_valid_q <= vel_valid_d;
        end
    end

    assign pos       = pos_q;
    assign dir       = dir_q;
    assign step      = step_q;
    assign err       = err_q;
    assign vel       = vel_q;
    assign vel_valid = vel_valid_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: a 12-bit-velocity instance plus a 4-bit one
// sharing the same inputs so velocity saturation is reachable in a short window.
module tb_quad_decoder;

    logic        clk_sys = 1'b0;
    logic        rst_n   = 1'b1;
    logic        enc_a   = 1'b0;
    logic        enc_b   = 1'b0;
    logic        pos_clr = 1'b0;
    logic        err_clr = 1'b0;
    logic [15:0] pos;
    logic        dir, step, vel_valid, err;
    logic [11:0] vel;
    logic [15:0] pos_s;
    logic        dir_s, step_s, vel_valid_s, err_s;
    logic [3:0]  vel_s;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [1:0]  ab    = 2'b00;

    always #5 clk_sys = ~clk_sys;

    quad_decoder #(.POS_W(16), .VEL_W(12), .FILT_LEN(4), .WIN_CYCLES(1000)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b),
        .pos_clr(pos_clr), .err_clr(err_clr), .pos(pos), .dir(dir), .step(step),
        .vel(vel), .vel_valid(vel_valid), .err(err)
    );

    quad_decoder #(.POS_W(16), .VEL_W(4), .FILT_LEN(4), .WIN_CYCLES(1000)) dut_sat (
        .clk_sys(clk_sys), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b),
        .pos_clr(pos_clr), .err_clr(err_clr), .pos(pos_s), .dir(dir_s), .step(step_s),
        .vel(vel_s), .vel_valid(vel_valid_s), .err(err_s)
    );

    function automatic logic [1:0] next_fwd(input logic [1:0] v);
        case (v)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] next_rev(input logic [1:0] v);
        case (v)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic tick();
        @(negedge clk_sys);
        cyc++;
    endtask

    task automatic set_ab(input logic [1:0] v);
        ab    = v;
        enc_a = v[1];
        enc_b = v[0];
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        tick();
        tick();
        n_cmp++; if (pos !== 16'h0000) begin n_bad++; $display("FAIL reset_pos: got %h want 0000", pos); end
        n_cmp++; if (dir !== 1'b1) begin n_bad++; $display("FAIL reset_dir: got %b want 1", dir); end
        n_cmp++; if (step !== 1'b0) begin n_bad++; $display("FAIL reset_step: got %b want 0", step); end
        n_cmp++; if (vel !== 12'h000) begin n_bad++; $display("FAIL reset_vel: got %h want 000", vel); end
        n_cmp++; if (vel_valid !== 1'b0) begin n_bad++; $display("FAIL reset_vel_valid: got %b want 0", vel_valid); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        rst_n = 1'b1;
        cyc   = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            n_cmp++; if (step !== 1'b0 || err !== 1'b0) begin
                n_bad++; $display("FAIL prime_quiet: cycle %0d step=%b err=%b want 0/0", cyc, step, err);
            end
        end
        $display("reset: pos=%h dir=%b err=%b", pos, dir, err);
    endtask

    task automatic test_forward();
        int nsteps = 0;
        for (int e = 0; e < 8; e++) begin
            set_ab(next_fwd(ab));
            for (int k = 1; k <= 10; k++) begin
                tick();
                if (step === 1'b1) nsteps++;
                n_cmp++; if (step !== (k == 7)) begin
                    n_bad++; $display("FAIL fwd_step_timing: edge %0d cycle %0d step=%b want %b", e, k, step, (k == 7));
                end
            end
            $display("forward edge %0d: ab=%b pos=%h dir=%b", e, ab, pos, dir);
        end
        n_cmp++; if (pos !== 16'd8) begin n_bad++; $display("FAIL fwd_pos: got %h want 0008", pos); end
        n_cmp++; if (dir !== 1'b1) begin n_bad++; $display("FAIL fwd_dir: got %b want 1", dir); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL fwd_err: got %b want 0", err); end
        n_cmp++; if (nsteps != 8) begin n_bad++; $display("FAIL fwd_nsteps: got %0d want 8", nsteps); end
    endtask

    task automatic test_reverse_wrap();
        pos_clr = 1'b1;
        tick();
        pos_clr = 1'b0;
        n_cmp++; if (pos !== 16'h0000) begin n_bad++; $display("FAIL clr_pos: got %h want 0000", pos); end
        set_ab(next_rev(ab));
        for (int k = 0; k < 10; k++) tick();
        $display("reverse edge 0: ab=%b pos=%h dir=%b", ab, pos, dir);
        n_cmp++; if (pos !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_pos: got %h want ffff", pos); end
        n_cmp++; if (dir !== 1'b0) begin n_bad++; $display("FAIL wrap_dir: got %b want 0", dir); end
        for (int e = 1; e < 4; e++) begin
            set_ab(next_rev(ab));
            for (int k = 0; k < 10; k++) tick();
            $display("reverse edge %0d: ab=%b pos=%h dir=%b", e, ab, pos, dir);
        end
        n_cmp++; if (pos !== 16'hFFFC) begin n_bad++; $display("FAIL rev4_pos: got %h want fffc", pos); end
        n_cmp++; if (dir !== 1'b0) begin n_bad++; $display("FAIL rev4_dir: got %b want 0", dir); end
    endtask

    task automatic test_glitch();
        logic [15:0] p0 = pos;
        logic [15:0] first_pos = 16'h0;
        logic        first_dir = 1'b0;
        int          nsteps = 0;
        enc_a = 1'b1;
        for (int k = 0; k < 3; k++) begin tick(); if (step === 1'b1) nsteps++; end
        enc_a = 1'b0;
        for (int k = 0; k < 15; k++) begin tick(); if (step === 1'b1) nsteps++; end
        $display("glitch 3-cycle: pos=%h steps=%0d", pos, nsteps);
        n_cmp++; if (nsteps != 0) begin n_bad++; $display("FAIL glitch3_steps: got %0d want 0", nsteps); end
        n_cmp++; if (pos !== p0) begin n_bad++; $display("FAIL glitch3_pos: got %h want %h", pos, p0); end
        enc_b = 1'b1;
        for (int k = 0; k < 24; k++) begin
            if (k == 4) enc_b = 1'b0;
            tick();
            if (step === 1'b1) begin
                if (nsteps == 0) begin first_pos = pos; first_dir = dir; end
                nsteps++;
            end
        end
        $display("glitch 4-cycle: pos=%h steps=%0d", pos, nsteps);
        n_cmp++; if (nsteps != 2) begin n_bad++; $display("FAIL glitch4_steps: got %0d want 2", nsteps); end
        n_cmp++; if (first_pos !== p0 + 16'd1 || first_dir !== 1'b1) begin
            n_bad++; $display("FAIL glitch4_first: pos=%h dir=%b want %h/1", first_pos, first_dir, p0 + 16'd1);
        end
        n_cmp++; if (pos !== p0 || dir !== 1'b0) begin
            n_bad++; $display("FAIL glitch4_final: pos=%h dir=%b want %h/0", pos, dir, p0);
        end
    endtask

    task automatic test_illegal();
        logic [15:0] p0 = pos;
        int          nsteps = 0;
        set_ab(2'b11);
        for (int k = 0; k < 10; k++) begin tick(); if (step === 1'b1) nsteps++; end
        $display("illegal 00->11: pos=%h err=%b", pos, err);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL illegal_err: got %b want 1", err); end
        n_cmp++; if (pos !== p0) begin n_bad++; $display("FAIL illegal_pos: got %h want %h", pos, p0); end
        n_cmp++; if (dir !== 1'b0) begin n_bad++; $display("FAIL illegal_dir: got %b want 0", dir); end
        set_ab(2'b00);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (step === 1'b1) nsteps++;
            if (k == 6) err_clr = 1'b1;
            if (k == 7) begin
                err_clr = 1'b0;
                n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_set_wins: got %b want 1", err); end
            end
        end
        $display("illegal 11->00 with err_clr: err=%b", err);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
        $display("err_clr alone: err=%b", err);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clr: got %b want 0", err); end
        n_cmp++; if (nsteps != 0 || pos !== p0) begin
            n_bad++; $display("FAIL illegal_nostep: steps=%0d pos=%h want 0/%h", nsteps, pos, p0);
        end
    endtask

    task automatic test_pos_clr_step();
        set_ab(next_fwd(ab));
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 6) pos_clr = 1'b1;
            if (k == 7) begin
                pos_clr = 1'b0;
                $display("pos_clr with step: pos=%h step=%b dir=%b", pos, step, dir);
                n_cmp++; if (pos !== 16'h0000) begin n_bad++; $display("FAIL clrstep_pos: got %h want 0000", pos); end
                n_cmp++; if (step !== 1'b1) begin n_bad++; $display("FAIL clrstep_step: got %b want 1", step); end
                n_cmp++; if (dir !== 1'b1) begin n_bad++; $display("FAIL clrstep_dir: got %b want 1", dir); end
            end
        end
        n_cmp++; if (pos !== 16'h0000) begin n_bad++; $display("FAIL clrstep_after: got %h want 0000", pos); end
    endtask

    task automatic test_reset_mid();
        int nsteps = 0;
        set_ab(next_fwd(ab));
        for (int k = 0; k < 10; k++) tick();
        set_ab(next_fwd(ab));
        for (int k = 0; k < 10; k++) tick();
        set_ab(next_rev(ab));
        for (int k = 0; k < 7; k++) tick();
        n_cmp++; if (pos !== 16'd1 || dir !== 1'b0 || step !== 1'b1) begin
            n_bad++; $display("FAIL mid_prereset: pos=%h dir=%b step=%b want 0001/0/1", pos, dir, step);
        end
        #2 rst_n = 1'b0;
        #1;
        $display("async reset: pos=%h dir=%b step=%b err=%b", pos, dir, step, err);
        n_cmp++; if (pos !== 16'h0000) begin n_bad++; $display("FAIL mid_pos: got %h want 0000", pos); end
        n_cmp++; if (dir !== 1'b1) begin n_bad++; $display("FAIL mid_dir: got %b want 1", dir); end
        n_cmp++; if (step !== 1'b0) begin n_bad++; $display("FAIL mid_step: got %b want 0", step); end
        for (int k = 0; k < 3; k++) tick();
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin tick(); if (step === 1'b1) nsteps++; end
        $display("re-prime with ab=%b: steps=%0d pos=%h", ab, nsteps, pos);
        n_cmp++; if (nsteps != 0) begin n_bad++; $display("FAIL reprime_steps: got %0d want 0", nsteps); end
        n_cmp++; if (pos !== 16'h0000 || err !== 1'b0) begin
            n_bad++; $display("FAIL reprime_state: pos=%h err=%b want 0000/0", pos, err);
        end
    endtask

    task automatic test_velocity();
        int early = 0;
        rst_n = 1'b0;
        set_ab(2'b00);
        for (int k = 0; k < 3; k++) tick();
        rst_n = 1'b1;
        cyc   = 0;
        while (cyc < 10) tick();
        for (int e = 0; e < 25; e++) begin
            set_ab(next_fwd(ab));
            for (int k = 0; k < 10; k++) begin tick(); if (vel_valid === 1'b1) early++; end
        end
        while (cyc < 999) begin tick(); if (vel_valid === 1'b1) early++; end
        n_cmp++; if (early != 0) begin n_bad++; $display("FAIL vel_early: %0d pulses before cycle 1000", early); end
        tick();
        $display("window 1 @%0d: vel=%h vel_valid=%b vel_sat=%h", cyc, vel, vel_valid, vel_s);
        n_cmp++; if (vel_valid !== 1'b1) begin n_bad++; $display("FAIL vel1_valid: got %b want 1", vel_valid); end
        n_cmp++; if (vel !== 12'd25) begin n_bad++; $display("FAIL vel1: got %h want 019", vel); end
        n_cmp++; if (vel_s !== 4'h7) begin n_bad++; $display("FAIL vel1_sat: got %h want 7", vel_s); end
        for (int e = 0; e < 120; e++) begin
            set_ab(next_rev(ab));
            for (int k = 0; k < 6; k++) begin
                tick();
                if (cyc == 1001) begin
                    n_cmp++; if (vel_valid !== 1'b0) begin n_bad++; $display("FAIL vel_pulse_width: got %b want 0", vel_valid); end
                end
            end
        end
        while (cyc < 1999) tick();
        tick();
        $display("window 2 @%0d: vel=%h vel_valid=%b vel_sat=%h", cyc, vel, vel_valid, vel_s);
        n_cmp++; if (vel_valid !== 1'b1) begin n_bad++; $display("FAIL vel2_valid: got %b want 1", vel_valid); end
        n_cmp++; if (vel !== 12'hF88) begin n_bad++; $display("FAIL vel2: got %h want f88", vel); end
        n_cmp++; if (vel_s !== 4'h8) begin n_bad++; $display("FAIL vel2_sat: got %h want 8", vel_s); end
        while (cyc < 3000) tick();
        $display("window 3 @%0d: vel=%h vel_valid=%b vel_sat=%h", cyc, vel, vel_valid, vel_s);
        n_cmp++; if (vel_valid !== 1'b1 || vel !== 12'h000 || vel_s !== 4'h0) begin
            n_bad++; $display("FAIL vel3: valid=%b vel=%h sat=%h want 1/000/0", vel_valid, vel, vel_s);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse_wrap();
        test_glitch();
        test_illegal();
        test_pos_clr_step();
        test_reset_mid();
        test_velocity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
